// File: rtl/image_buffer_writer_pkg.sv
// Shared definitions for the frame-store write side: SRAM geometry, FSM states
// and the last-word address derivation.
package image_buffer_writer_pkg;

    localparam int unsigned PixelW     = 8;
    localparam int unsigned SramDataW  = 32;
    localparam int unsigned SramAddrW  = 18;
    localparam int unsigned WordAddrW  = SramAddrW - 1;
    localparam int unsigned PixPerWord = SramDataW / PixelW;
    localparam int unsigned CountW     = 16;

    typedef enum logic [1:0] {
        StWrite,
        StFlush,
        StAckLow,
        StReq
    } state_e;

    // Index of the last SRAM word in a frame of n_pixel pixels.
    function automatic logic [WordAddrW-1:0] max_addr(input int unsigned n_pixel);
        return WordAddrW'(n_pixel / PixPerWord - 1);
    endfunction

endpackage

// File: rtl/image_buffer_writer_if.sv
// Pixel stream, SRAM write port and swap handshake of the buffer writer.
// master: the writer itself; slave: its surroundings (pipeline, arbiter, reader).
interface image_buffer_writer_if;
    import image_buffer_writer_pkg::*;

    logic [PixelW-1:0]    pixel;
    logic                 pixel_valid;
    logic                 pixel_ready;
    logic                 swap;
    logic                 swap_ack;
    logic                 wr_valid;
    logic [SramAddrW-1:0] wr_addr;
    logic [SramDataW-1:0] wr_data;
    logic                 wr_ready;
    logic [CountW-1:0]    frame_count;

    modport master (
        input  pixel, pixel_valid, swap_ack, wr_ready,
        output pixel_ready, swap, wr_valid, wr_addr, wr_data, frame_count
    );

    modport slave (
        output pixel, pixel_valid, swap_ack, wr_ready,
        input  pixel_ready, swap, wr_valid, wr_addr, wr_data, frame_count
    );

endinterface

// File: rtl/image_buffer_writer_pixel_packer.sv
// Packs four 8-bit pixels into one 32-bit SRAM word and holds it in a one-deep
// output register until the arbiter takes it.
module image_buffer_writer_pixel_packer
    import image_buffer_writer_pkg::*;
#(
    parameter logic [WordAddrW-1:0] MaxAddr    = '1,
    parameter bit                   StartFrame = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic                 clear,
    input  logic [PixelW-1:0]    pixel,
    input  logic                 pixel_valid,
    output logic                 pixel_ready,
    input  logic                 frame,
    input  logic [WordAddrW-1:0] word_addr,
    output logic                 wr_valid,
    output logic [SramAddrW-1:0] wr_addr,
    output logic [SramDataW-1:0] wr_data,
    input  logic                 wr_ready,
    output logic                 wr_fire,
    output logic                 last_loaded
);

    logic [1:0]                     pix_idx_q, pix_idx_d;
    logic [3*PixelW-1:0]            pack_q, pack_d;
    logic                           wr_valid_q, wr_valid_d;
    logic [SramAddrW-1:0]           wr_addr_q, wr_addr_d;
    logic [SramDataW-1:0]           wr_data_q, wr_data_d;
    logic                           pix_accept;
    logic                           load;

    // The completing pixel needs a free output slot, or one draining this very cycle.
    assign pixel_ready = enable & ~rst & ~((pix_idx_q == 2'd3) & wr_valid_q & ~wr_ready);
    assign pix_accept  = pixel_valid & pixel_ready;
    assign load        = pix_accept & (pix_idx_q == 2'd3);
    assign wr_fire     = wr_valid_q & wr_ready;
    assign last_loaded = load & (word_addr == MaxAddr);

    assign wr_valid = wr_valid_q;
    assign wr_addr  = wr_addr_q;
    assign wr_data  = wr_data_q;

    // Next state of the pack register, pixel index and output register.
    always_comb begin
        pix_idx_d  = pix_idx_q;
        pack_d     = pack_q;
        wr_valid_d = wr_valid_q;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        if (wr_fire) begin
            wr_valid_d = 1'b0;
        end
        if (clear) begin
            pix_idx_d = 2'd0;
        end else if (pix_accept) begin
            pix_idx_d = pix_idx_q + 2'd1;
            unique case (pix_idx_q)
                2'd0: pack_d[7:0]   = pixel;
                2'd1: pack_d[15:8]  = pixel;
                2'd2: pack_d[23:16] = pixel;
                2'd3: begin
                    wr_valid_d = 1'b1;
                    wr_data_d  = {pixel, pack_q};
                    wr_addr_d  = {frame, word_addr};
                end
            endcase
        end
    end

    // Packer state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pix_idx_q  <= 2'd0;
            pack_q     <= '0;
            wr_valid_q <= 1'b0;
            wr_addr_q  <= {StartFrame, {WordAddrW{1'b0}}};
            wr_data_q  <= '0;
        end else begin
            pix_idx_q  <= pix_idx_d;
            pack_q     <= pack_d;
            wr_valid_q <= wr_valid_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
        end
    end

endmodule

// File: rtl/image_buffer_writer.sv
// Write side of the double-buffered SRAM frame store: feeds packed pixel words
// into the back buffer, then swaps buffers with the reader via a four-phase
// swap/swap_ack handshake.
module image_buffer_writer
    import image_buffer_writer_pkg::*;
#(
    parameter bit          START_FRAME = 1'b1,
    parameter int unsigned N_PIXEL     = 480000
) (
    input logic                  clk,
    input logic                  rst,
    image_buffer_writer_if.master bus
);

    localparam logic [WordAddrW-1:0] MaxAddr = max_addr(N_PIXEL);

    state_e                 state_q, state_d;
    logic                   frame_q, frame_d;
    logic [WordAddrW-1:0]   word_addr_q, word_addr_d;
    logic [CountW-1:0]      frame_count_q, frame_count_d;
    logic                   swap_q, swap_d;
    logic [WordAddrW-1:0]   load_addr;
    logic                   enable;
    logic                   clear;
    logic                   wr_fire;
    logic                   last_loaded;

    // A word accepted this cycle frees the slot, so a word loaded now takes the next address.
    assign load_addr = (wr_fire && (word_addr_q != MaxAddr)) ?
                       word_addr_q + WordAddrW'(1) : word_addr_q;
    assign enable    = (state_q == StWrite);

    assign bus.swap        = swap_q;
    assign bus.frame_count = frame_count_q;

    // Frame sequencing: write, drain the final word, wait for a clean ack low, request swap.
    always_comb begin
        state_d       = state_q;
        frame_d       = frame_q;
        word_addr_d   = load_addr;
        frame_count_d = frame_count_q;
        swap_d        = 1'b0;
        clear         = 1'b0;
        unique case (state_q)
            StWrite: begin
                if (last_loaded) state_d = StFlush;
            end
            StFlush: begin
                if (wr_fire) state_d = StAckLow;
            end
            StAckLow: begin
                // A stale ack from the previous swap must drop before a new request.
                if (!bus.swap_ack) state_d = StReq;
            end
            StReq: begin
                if (bus.swap_ack) begin
                    state_d       = StWrite;
                    frame_d       = ~frame_q;
                    word_addr_d   = '0;
                    frame_count_d = frame_count_q + CountW'(1);
                    clear         = 1'b1;
                end else begin
                    swap_d = 1'b1;
                end
            end
            default: state_d = StWrite;
        endcase
    end

    // FSM, frame bit, word address, frame counter and swap registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= StWrite;
            frame_q       <= START_FRAME;
            word_addr_q   <= '0;
            frame_count_q <= '0;
            swap_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            frame_q       <= frame_d;
            word_addr_q   <= word_addr_d;
            frame_count_q <= frame_count_d;
            swap_q        <= swap_d;
        end
    end

    image_buffer_writer_pixel_packer #(
        .MaxAddr    (MaxAddr),
        .StartFrame (START_FRAME)
    ) u_packer (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .clear       (clear),
        .pixel       (bus.pixel),
        .pixel_valid (bus.pixel_valid),
        .pixel_ready (bus.pixel_ready),
        .frame       (frame_q),
        .word_addr   (load_addr),
        .wr_valid    (bus.wr_valid),
        .wr_addr     (bus.wr_addr),
        .wr_data     (bus.wr_data),
        .wr_ready    (bus.wr_ready),
        .wr_fire     (wr_fire),
        .last_loaded (last_loaded)
    );

endmodule

// File: doc/image_buffer_writer.md
# image_buffer_writer

Write-side partner of the SRAM double-buffered frame store. Accepts an 8-bit pixel stream, packs four pixels per 32-bit word, and issues word writes through the SRAM arbiter into the back buffer. When a frame completes, it runs a four-phase swap handshake with the display-side buffer reader, then flips to the other buffer. Sits between the image pipeline output and the SRAM arbiter's write port.

## Interface
- START_FRAME, 1'b1, buffer bit used for the first written frame; must be the opposite of the reader's start frame.
- N_PIXEL, 480000, pixels per frame; must be a multiple of 4. MAX_ADDR = N_PIXEL/4 − 1.
- clock  in  1  sole clock.
- reset  in  1  asynchronous, active-high.
- pixel  in  8  pixel value.
- pixel_valid  in  1  pixel present.
- pixel_ready  out  1  pixel accepted on a cycle where pixel_valid & pixel_ready.
- swap  out  1  swap request to the reader.
- swap_ack  in  1  reader acknowledge; high once the reader has flipped buffers.
- wr_valid  out  1  write request valid.
- wr_addr  out  18  {frame, word_addr[16:0]}.
- wr_data  out  32  packed word; pixel k of the word in bits [8k+7:8k].
- wr_ready  in  1  arbiter accepts the write on wr_valid & wr_ready.
- frame_count  out  16  completed swaps; wraps at 2^16.

## Operation
- States: WRITE, FLUSH, ACK_LOW, REQ. Reset state is WRITE.
- Packer: 2-bit pix_idx plus 24-bit pack register. Pixels 0–2 are stored in the pack register.
  - On the pixel with pix_idx==3, {pixel, pack} loads the output register.
  - That load sets wr_valid and wr_addr={frame, word_addr}.
  - pix_idx wraps 3→0.
- Output register: one word deep.
  - wr_valid, wr_addr and wr_data hold stable until wr_ready.
  - On acceptance, word_addr increments, except after MAX_ADDR.
- pixel_ready = (state==WRITE) & ~(pix_idx==3 & wr_valid & ~wr_ready).
  - A 4th pixel may be accepted in the same cycle the previous word is accepted.
- WRITE→FLUSH: when the word carrying word_addr==MAX_ADDR is loaded. pixel_ready is 0 from then on.
- FLUSH→ACK_LOW: when that final word is accepted.
- ACK_LOW: swap=0. Go to REQ when swap_ack==0. This guards against a stale acknowledge left over from the previous frame.
- REQ: swap=1. When swap_ack==1:
  - toggle frame
  - word_addr←0, pix_idx←0
  - frame_count+1
  - swap←0
  - go to WRITE
- swap is a register: high only in REQ, low in every other state.
- Reset values: swap 0, wr_valid 0, wr_addr {START_FRAME,17'd0}, wr_data 0, frame_count 0, pix_idx 0. pixel_ready is 0 while reset is asserted.
- Reset mid-frame: the partial word and any pending write are discarded, and the next frame restarts at word 0 of START_FRAME.
- pixel_valid with pixel_ready low: nothing is captured. Upstream must hold.

## Timing
- Latency: 4th pixel accepted at edge N → wr_valid high after edge N, acceptable at edge N+1.
- Throughput: 1 pixel/cycle sustained while wr_ready is asserted at least one cycle in four.
- Frame end, with wr_ready=1 and swap_ack=0:
  - last word accepted at edge F
  - ACK_LOW during F→F+1
  - swap high from edge F+2
- Ack: swap_ack seen high at edge A → frame toggles, swap falls, and pixel_ready is 1 after edge A.
- swap_ack is sampled only in ACK_LOW and REQ. It is ignored in WRITE and FLUSH.
- word_addr never exceeds MAX_ADDR. Wrap to 0 happens only through REQ.

## Structure
- Shared header `include: state encodings, MAX_ADDR derivation, SRAM word/address widths (32/18).
- One natural sub-module, pixel_packer: pack register, pix_idx, output register, and the wr_valid/wr_ready handshake.
  - Controls: enable and clear.
  - Flag: last_loaded (asserted when word MAX_ADDR is loaded).
- Top level holds the FSM, frame bit, word_addr and frame_count. Target 150–250 lines total.

## Test plan
- Pixels 0x01,0x02,0x03,0x04 with wr_ready=1 → one write, wr_data=0x04030201, wr_addr={1,0}, wr_valid for one cycle.
- wr_ready held 0 for 10 cycles with a continuous stream → exactly 7 pixels accepted (3 packed + 4th blocked); wr_data/wr_addr stable; no loss or duplication once released.
- N_PIXEL=16, full frame, swap_ack raised 3 cycles after swap:
  - writes to addrs {1,0..3}
  - swap stays high until ack
  - frame toggles, frame_count=1
  - next writes go to {0,0}
- swap_ack held high at frame end → stays in ACK_LOW with swap=0. Dropping ack → swap rises the cycle after.
- Reset asserted asynchronously mid-word (pix_idx=2) and mid-REQ → outputs return to reset values immediately. The next frame starts at {START_FRAME,0} with the first pixel in bits [7:0].
- Random pixel_valid/wr_ready/ack delays over 3 frames of N_PIXEL=64 → scoreboard matches every word and address; frame_count=3.
